block_put: RTL and testbench

//  Write-back stage after the block compute path. Takes a JxK result block and

---
 rtl/block_put.sv | 184 ++++++++++++++++++
 tb/tb_block_put.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_put.sv
// block_put: write-back stage that scatters a JxK result block into a
// row-major result matrix memory, clipping elements outside the matrix.
// Overwrite mode writes each element; accumulate mode does read-modify-write.
module block_put #(
    parameter int J      = 2,
    parameter int K      = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           accumulate,
    input  logic [9:0]                     start_row,
    input  logic [9:0]                     start_col,
    input  logic [9:0]                     num_cols,
    input  logic [9:0]                     matrix_len,
    input  logic [J*K-1:0][DATA_W-1:0]     block,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic                           mem_we,
    output logic [DATA_W-1:0]              mem_wdata,
    output logic                           mem_re,
    input  logic [DATA_W-1:0]              mem_rdata
);

    localparam int IW = (J > 1) ? $clog2(J) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int NW = (J * K > 1) ? $clog2(J * K) : 1;

    // VISIT is a pure decision point: it is resolved combinationally into
    // SKIP, WR or RD, so the state register never actually holds it.
    typedef enum logic [2:0] {
        IDLE,
        VISIT,
        SKIP,
        WR,
        RD,
        WT,
        DONE
    } state_t;

    state_t state, next_state;

    logic [9:0]                 lat_row, lat_col, lat_cols, lat_len;
    logic                       lat_acc;
    logic [J*K-1:0][DATA_W-1:0] lat_block;

    logic [IW-1:0] i_idx, nxt_i;
    logic [KW-1:0] j_idx, nxt_j;
    logic [NW-1:0] n_idx, nxt_n;

    logic [9:0]                 src_row, src_col, src_cols, src_len, rows;
    logic                       src_acc;
    logic [J*K-1:0][DATA_W-1:0] src_block;
    logic [10:0]                row_sum, col_sum;
    logic                       in_range, last_elem, visit;
    logic [ADDR_W-1:0]          visit_addr;
    logic [DATA_W-1:0]          visit_elem;

    // Element 0 is dispatched on the start edge itself, so while idle the
    // dispatch logic looks at the live inputs instead of the latched copy.
    always_comb begin
        if (state == IDLE) begin
            src_row   = start_row;
            src_col   = start_col;
            src_cols  = num_cols;
            src_len   = matrix_len;
            src_acc   = accumulate;
            src_block = block;
        end else begin
            src_row   = lat_row;
            src_col   = lat_col;
            src_cols  = lat_cols;
            src_len   = lat_len;
            src_acc   = lat_acc;
            src_block = lat_block;
        end
    end

    // Row-major walk: pick the element that the next dispatch will visit.
    always_comb begin
        last_elem = (i_idx == IW'(J - 1)) && (j_idx == KW'(K - 1));
        nxt_i     = i_idx;
        nxt_j     = j_idx;
        nxt_n     = n_idx + 1'b1;
        if (state == IDLE) begin
            nxt_i = '0;
            nxt_j = '0;
            nxt_n = '0;
        end else if (j_idx == KW'(K - 1)) begin
            nxt_i = i_idx + 1'b1;
            nxt_j = '0;
        end else begin
            nxt_j = j_idx + 1'b1;
        end
    end

    // Range test and address for the element being dispatched; sums are
    // kept one bit wider so an origin near the top cannot wrap into range.
    always_comb begin
        rows       = (src_cols == 10'd0) ? 10'd0 : src_len / src_cols;
        row_sum    = {1'b0, src_row} + 11'(nxt_i);
        col_sum    = {1'b0, src_col} + 11'(nxt_j);
        in_range   = (row_sum < {1'b0, rows}) && (col_sum < {1'b0, src_cols});
        visit_addr = ADDR_W'(20'(row_sum) * 20'(src_cols) + 20'(col_sum));
        visit_elem = src_block[nxt_n];
    end

    // Next-state logic; any transition into VISIT is dispatched immediately.
    always_comb begin
        next_state = state;
        visit      = 1'b0;
        case (state)
            IDLE:     if (start) visit = 1'b1;
            SKIP, WR: if (last_elem) next_state = DONE;
                      else visit = 1'b1;
            RD:       next_state = WT;
            WT:       next_state = WR;
            DONE:     next_state = IDLE;
            VISIT:    visit = 1'b1;
            default:  next_state = IDLE;
        endcase
        if (visit) begin
            if (!in_range)    next_state = SKIP;
            else if (src_acc) next_state = RD;
            else              next_state = WR;
        end
    end

    // Snapshot every request input when a start is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_row   <= '0;
            lat_col   <= '0;
            lat_cols  <= '0;
            lat_len   <= '0;
            lat_acc   <= 1'b0;
            lat_block <= '0;
        end else if (state == IDLE && start) begin
            lat_row   <= start_row;
            lat_col   <= start_col;
            lat_cols  <= num_cols;
            lat_len   <= matrix_len;
            lat_acc   <= accumulate;
            lat_block <= block;
        end
    end

    // State, element index and registered memory/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            i_idx     <= '0;
            j_idx     <= '0;
            n_idx     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= next_state;
            busy   <= (next_state != IDLE) && (next_state != DONE);
            done   <= (next_state == DONE);
            mem_we <= (next_state == WR);
            mem_re <= (next_state == RD);
            if (visit) begin
                i_idx    <= nxt_i;
                j_idx    <= nxt_j;
                n_idx    <= nxt_n;
                mem_addr <= visit_addr;
            end
            if (visit && next_state == WR) begin
                mem_wdata <= visit_elem;
            end else if (state == WT) begin
                mem_wdata <= mem_rdata + lat_block[n_idx];
            end
        end
    end

endmodule

// File: tb/tb_block_put.sv
// tb_block_put: directed and randomized checks of block_put against a
// behavioural model of the write-back rules and a simple memory model.
module tb_block_put;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              accumulate;
    logic [9:0]        start_row, start_col, num_cols, matrix_len;
    logic [3:0][15:0]  block;
    logic              busy, done, mem_we, mem_re;
    logic [9:0]        mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] tbmem [1024];
    logic [15:0] e_mem [1024];
    bit          e_we [64];
    bit          e_re [64];
    int          e_addr [64];
    logic [15:0] e_data [64];

    block_put #(.J(2), .K(2), .DATA_W(16), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .accumulate (accumulate),
        .start_row  (start_row),
        .start_col  (start_col),
        .num_cols   (num_cols),
        .matrix_len (matrix_len),
        .block      (block),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Result memory: synchronous write, read data valid the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) tbmem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= tbmem[mem_addr];
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic prefill();
        for (int a = 0; a < 1024; a++) tbmem[a] = 16'(a);
    endtask

    // Runs one block write-back and checks every cycle against the model.
    // repulse_c: cycle where start is pulsed again; rst_c: cycle where reset hits.
    task automatic applyStimulus(input bit acc, input int sr, input int sc,
                                 input int nc, input int ml,
                                 input logic [3:0][15:0] blk,
                                 input int repulse_c, input int rst_c);
        int rows, c, a, done_c, bad;
        bit aborted;
        logic [15:0] sum;
        for (int k = 0; k < 64; k++) begin
            e_we[k] = 1'b0; e_re[k] = 1'b0; e_addr[k] = 0; e_data[k] = '0;
        end
        for (int k = 0; k < 1024; k++) e_mem[k] = tbmem[k];
        rows = (nc == 0) ? 0 : ml / nc;
        c = 1;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                if ((sr + i) < rows && (sc + j) < nc) begin
                    a = ((sr + i) * nc + sc + j) % 1024;
                    if (!acc) begin
                        e_we[c] = 1'b1; e_addr[c] = a; e_data[c] = blk[i*2+j];
                        e_mem[a] = blk[i*2+j];
                        c += 1;
                    end else begin
                        sum = tbmem[a] + blk[i*2+j];
                        e_re[c] = 1'b1; e_addr[c] = a;
                        e_we[c+2] = 1'b1; e_addr[c+2] = a; e_data[c+2] = sum;
                        e_mem[a] = sum;
                        c += 3;
                    end
                end else begin
                    c += 1;
                end
            end
        end
        done_c = c;
        aborted = 1'b0;

        @(negedge clk);
        accumulate = acc;
        start_row  = 10'(sr);
        start_col  = 10'(sc);
        num_cols   = 10'(nc);
        matrix_len = 10'(ml);
        block      = blk;
        start      = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= done_c; cyc++) begin
            if (cyc == rst_c) begin
                rst = 1'b1;
                #1;
                checkOutput("abort busy", busy, 0);
                checkOutput("abort done", done, 0);
                checkOutput("abort we", mem_we, 0);
                checkOutput("abort re", mem_re, 0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            checkOutput($sformatf("we c%0d", cyc), mem_we, e_we[cyc]);
            checkOutput($sformatf("re c%0d", cyc), mem_re, e_re[cyc]);
            checkOutput($sformatf("busy c%0d", cyc), busy, (cyc < done_c));
            checkOutput($sformatf("done c%0d", cyc), done, (cyc == done_c));
            if (e_we[cyc] || e_re[cyc])
                checkOutput($sformatf("addr c%0d", cyc), mem_addr, e_addr[cyc]);
            if (e_we[cyc])
                checkOutput($sformatf("wdata c%0d", cyc), mem_wdata, e_data[cyc]);
            start      = (cyc == repulse_c);
            block      = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            start_row  = 10'($urandom);
            start_col  = 10'($urandom);
            accumulate = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        if (!aborted) begin
            checkOutput("idle busy", busy, 0);
            checkOutput("idle done", done, 0);
            checkOutput("idle we", mem_we, 0);
            checkOutput("idle re", mem_re, 0);
            bad = 0;
            for (int k = 0; k < 1024; k++) if (tbmem[k] !== e_mem[k]) bad++;
            checkOutput("mem image diffs", bad, 0);
        end
    endtask

    initial begin
        logic [3:0][15:0] blk;
        int sr, sc, nc, ml;
        rst = 1'b1; start = 1'b0; accumulate = 1'b0;
        start_row = '0; start_col = '0; num_cols = '0; matrix_len = '0;
        block = '0;
        prefill();
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset we", mem_we, 0);
        checkOutput("reset re", mem_re, 0);
        checkOutput("reset addr", mem_addr, 0);
        checkOutput("reset wdata", mem_wdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Overwrite inside a 4x4 matrix.
        prefill();
        applyStimulus(1'b0, 1, 1, 4, 16, {16'd4, 16'd3, 16'd2, 16'd1}, -1, -1);
        checkOutput("t1 mem5", tbmem[5], 1);
        checkOutput("t1 mem10", tbmem[10], 4);

        // Accumulate at the origin.
        prefill();
        applyStimulus(1'b1, 0, 0, 4, 16, {16'd40, 16'd30, 16'd20, 16'd10}, -1, -1);
        checkOutput("t2 mem5", tbmem[5], 45);
        checkOutput("t2 mem4", tbmem[4], 34);

        // Corner clip, both modes.
        prefill();
        applyStimulus(1'b0, 3, 3, 4, 16, {16'd6, 16'd9, 16'd8, 16'd7}, -1, -1);
        checkOutput("t3 mem15", tbmem[15], 7);
        prefill();
        applyStimulus(1'b1, 3, 3, 4, 16, {16'd6, 16'd9, 16'd8, 16'd7}, -1, -1);
        checkOutput("t3a mem15", tbmem[15], 22);

        // Accumulate wraps modulo 2^16.
        prefill();
        tbmem[0] = 16'd2;
        applyStimulus(1'b1, 0, 0, 4, 16, {16'd0, 16'd0, 16'd0, 16'hFFFF}, -1, -1);
        checkOutput("t4 wrap", tbmem[0], 1);

        // start pulsed again while busy, then a zero-column matrix.
        prefill();
        applyStimulus(1'b0, 1, 1, 4, 16, {16'd4, 16'd3, 16'd2, 16'd1}, 2, -1);
        prefill();
        applyStimulus(1'b0, 0, 0, 0, 16, {16'd4, 16'd3, 16'd2, 16'd1}, -1, -1);

        // Reset lands after element 0's write-back, during element 1's read.
        prefill();
        applyStimulus(1'b1, 0, 0, 4, 16, {16'd40, 16'd30, 16'd20, 16'd10}, -1, 4);
        checkOutput("t6 mem0", tbmem[0], 10);
        checkOutput("t6 mem1", tbmem[1], 1);
        prefill();
        applyStimulus(1'b0, 1, 1, 4, 16, {16'd4, 16'd3, 16'd2, 16'd1}, -1, -1);

        // Origin row at the top of the 10-bit range must not wrap into range.
        prefill();
        applyStimulus(1'b0, 1023, 0, 4, 16, {16'd4, 16'd3, 16'd2, 16'd1}, -1, -1);

        // Randomized shapes, origins, modes and memory contents.
        for (int t = 0; t < 24; t++) begin
            for (int a = 0; a < 1024; a++) tbmem[a] = 16'($urandom);
            nc = $urandom_range(0, 6);
            ml = $urandom_range(0, 40);
            sr = $urandom_range(0, 7);
            sc = $urandom_range(0, 7);
            blk = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            applyStimulus(1'($urandom), sr, sc, nc, ml, blk, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
